mem_wb_pipe_stage: RTL and testbench
====================================

// Module: mem_wb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer, flush.
//  Sits between the MEM stage (ALU result, memory read data) and the WB stage / register file.
//  Resolves the writeback value (load vs ALU) on entry, so WB receives one final wb_data word.
//  Replaces fixed-width MEM/WB latches; adds back-pressure, bubbles and squash.
// PARAMETERS
//  OPC_W     4        opcode width
//  ALU_W     16       ALU result width
//  MEM_W     20       memory read-data width; wb_data width = MEM_W (MEM_W >= ALU_W required)
//  RD_W      3        destination-register index width
//  LOAD_OPC  4'b0010  opcode whose writeback source is memory data (width OPC_W)
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  flush         in   1      squash all held entries
//  in_valid      in   1      MEM stage presents an entry
//  in_ready      out  1      stage can accept an entry this cycle
//  in_opcode     in   OPC_W  opcode of the entry
//  in_alu        in   ALU_W  ALU result
//  in_mem        in   MEM_W  memory read data
//  in_rd         in   RD_W   destination register
//  in_regwrite   in   1      entry writes the register file
//  out_valid     out  1      WB entry valid
//  out_ready     in   1      WB consumes the entry
//  out_opcode    out  OPC_W  registered opcode
//  out_rd        out  RD_W   registered destination
//  out_regwrite  out  1      registered write enable; only meaningful when out_valid=1
//  wb_data       out  MEM_W  writeback value
// BEHAVIOUR
//  - Storage: main reg (drives outputs) + skid reg. in_ready = !skid_valid (registered; never depends on in_valid).
//  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
//  - Entry formation: wb = (in_opcode==LOAD_OPC) ? in_mem : {zero-extend in_alu to MEM_W}.
//  - Latency: accepted entry appears on outputs the next cycle when the main reg is empty or draining.
//  - Main empty or draining, skid empty: accept loads main directly; no accept -> main valid clears on drain.
//  - Main full, not draining, accept: entry goes to skid; in_ready drops the next cycle.
//  - Skid full, drain: skid moves to main, skid_valid clears, in_ready rises the next cycle.
//  - Order preserved: entries leave in acceptance order; no entry dropped or duplicated.
//  - Accept and drain in the same cycle with skid empty: main replaced by the new entry, out_valid stays 1.
//  - flush (edge-sampled): main_valid and skid_valid cleared; an accept in that cycle is discarded.
//    Data regs may keep stale values. Flush has priority over accept and drain.
//  - reset: same as flush, plus out_opcode, out_rd, out_regwrite and wb_data all forced to 0; out_valid=0.
//    in_ready=1 from the first post-reset cycle. Reset mid-stall discards both entries.
//  - While out_valid=0, out_regwrite is 0 (bubble never writes).
//  - out_* stable while out_valid & !out_ready (no change until drained).
// CONFIGURATION
//  MEM_WB_FWD_EN defined: extra outputs fwd_valid(1), fwd_rd(RD_W), fwd_data(MEM_W).
//    fwd_valid = out_valid & out_regwrite; fwd_rd/fwd_data mirror out_rd/wb_data.
//    Combinational from the main reg, for EX-stage forwarding.
//  Not defined: ports absent; no forwarding logic; core behaviour identical.
// TESTING
//  1 reset=1 for 2 cycles, then release -> out_valid=0, wb_data=0, out_regwrite=0, in_ready=1.
//  2 in_valid=1, opcode=0001, alu=16'h00A5, rd=3, out_ready=1 -> next cycle out_valid=1, wb_data=20'h000A5, out_rd=3.
//  3 opcode=LOAD_OPC, mem=20'hABCDE, alu=16'h1234 -> wb_data=20'hABCDE one cycle later.
//  4 out_ready=0, push E1,E2 -> in_ready=0 after E2; out_ready=1 -> E1 then E2 on consecutive cycles, in_ready=1.
//  5 main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
//  6 MEM_WB_FWD_EN: entry rd=5, regwrite=1, alu=16'h0042 held -> fwd_valid=1, fwd_rd=5, fwd_data=20'h00042.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB stage: 2-entry skid buffer, flush, 1-cycle latency; in_ready = !skid_valid (registered).
// Define MEM_WB_FWD_EN to expose combinational forwarding taps (fwd_valid/fwd_rd/fwd_data) from the main reg.
module mem_wb_pipe_stage #(
  parameter int               OPC_W    = 4,
  parameter int               ALU_W    = 16,
  parameter int               MEM_W    = 20,
  parameter int               RD_W     = 3,
  parameter logic [OPC_W-1:0] LOAD_OPC = 4'b0010
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [ALU_W-1:0] in_alu,
  input  logic [MEM_W-1:0] in_mem,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_regwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] out_opcode,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_regwrite,
  output logic [MEM_W-1:0] wb_data
`ifdef MEM_WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [MEM_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RD_W-1:0]  rd;
    logic             regwrite;
    logic [MEM_W-1:0] wb;
  } entry_t;

  entry_t main_q, skid_q, in_ent;
  logic   main_valid, skid_valid;
  logic   accept, drain;

  // Writeback source is resolved here so WB only ever sees one data word.
  always_comb begin
    in_ent          = '0;
    in_ent.opcode   = in_opcode;
    in_ent.rd       = in_rd;
    in_ent.regwrite = in_regwrite;
    in_ent.wb       = (in_opcode == LOAD_OPC) ? in_mem : MEM_W'(in_alu);
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so no new entry can arrive this cycle.
      if (drain) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || drain) begin
      main_valid <= accept;
      if (accept) main_q <= in_ent;
    end else if (accept) begin
      skid_q     <= in_ent;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid    = main_valid;
  assign out_opcode   = main_q.opcode;
  assign out_rd       = main_q.rd;
  assign out_regwrite = main_valid & main_q.regwrite;
  assign wb_data      = main_q.wb;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid & out_regwrite;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.wb;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench for mem_wb_pipe_stage: reset, ALU/load select, skid stall, flush, reset mid-stall, forwarding.
module tb_mem_wb_pipe_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_regwrite;
  logic [3:0]  in_opcode, out_opcode;
  logic [15:0] in_alu;
  logic [19:0] in_mem, wb_data;
  logic [2:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_regwrite;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [19:0] fwd_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mem_wb_pipe_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_alu(in_alu), .in_mem(in_mem),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .wb_data(wb_data)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] alu,
                       input logic [19:0] mem, input logic [2:0] rd, input logic rw);
    in_valid    = v;
    in_opcode   = opc;
    in_alu      = alu;
    in_mem      = mem;
    in_rd       = rd;
    in_regwrite = rw;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_out_regwrite", out_regwrite, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_opcode", out_opcode, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // ALU writeback, zero-extended
    out_ready = 1'b1;
    drive(1'b1, 4'h1, 16'h00A5, 20'h55555, 3'd3, 1'b1);
    tick();
    check("alu_out_valid", out_valid, 1);
    check("alu_wb_data", wb_data, 20'h000A5);
    check("alu_out_rd", out_rd, 3);
    check("alu_out_opcode", out_opcode, 1);
    check("alu_out_regwrite", out_regwrite, 1);

    // Load writeback replaces draining entry in the same cycle
    drive(1'b1, 4'h2, 16'h1234, 20'hABCDE, 3'd6, 1'b1);
    tick();
    check("load_out_valid", out_valid, 1);
    check("load_wb_data", wb_data, 20'hABCDE);
    check("load_out_rd", out_rd, 6);
    check("load_in_ready", in_ready, 1);
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick();
    check("bubble_out_valid", out_valid, 0);
    check("bubble_out_regwrite", out_regwrite, 0);

    // Stall: E1 in main, E2 in skid, E3 held off until space frees
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 16'h0111, 20'h0, 3'd1, 1'b1);
    tick();
    check("e1_out_valid", out_valid, 1);
    check("e1_wb_data", wb_data, 20'h00111);
    check("e1_in_ready", in_ready, 1);
    drive(1'b1, 4'h2, 16'h0FFF, 20'h22222, 3'd2, 1'b0);
    tick();
    check("e2_in_ready", in_ready, 0);
    check("e2_hold_wb_data", wb_data, 20'h00111);
    check("e2_hold_out_rd", out_rd, 1);
    drive(1'b1, 4'h4, 16'h0333, 20'h0, 3'd4, 1'b1);
    tick();
    check("stall_in_ready", in_ready, 0);
    check("stall_wb_data", wb_data, 20'h00111);
    check("stall_out_opcode", out_opcode, 3);
    out_ready = 1'b1;
    tick();
    check("drain_e2_wb_data", wb_data, 20'h22222);
    check("drain_e2_out_rd", out_rd, 2);
    check("drain_e2_out_regwrite", out_regwrite, 0);
    check("drain_e2_in_ready", in_ready, 1);
    tick();
    check("drain_e3_out_valid", out_valid, 1);
    check("drain_e3_wb_data", wb_data, 20'h00333);
    check("drain_e3_out_rd", out_rd, 4);
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick();
    check("drain_empty_out_valid", out_valid, 0);

    // Flush with both regs full and an input presented
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0AAA, 20'h0, 3'd1, 1'b1);
    tick();
    drive(1'b1, 4'h1, 16'h0BBB, 20'h0, 3'd2, 1'b1);
    tick();
    check("pre_flush_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 4'h1, 16'h0CCC, 20'h0, 3'd7, 1'b1);
    tick();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_out_regwrite", out_regwrite, 0);
    // Flush while in_ready=1: the accepted input is discarded
    tick();
    check("flush_accept_out_valid", out_valid, 0);
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("post_flush_out_valid", out_valid, 0);

    // Reset mid-stall discards both entries and clears data
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0DDD, 20'h0, 3'd5, 1'b1);
    tick();
    drive(1'b1, 4'h1, 16'h0EEE, 20'h0, 3'd6, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_wb_data", wb_data, 0);
    check("midrst_out_rd", out_rd, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("midrst_after_out_valid", out_valid, 0);

    // Held entry for forwarding taps
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0042, 20'h0, 3'd5, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick();
    check("hold_wb_data", wb_data, 20'h00042);
    check("hold_out_rd", out_rd, 5);
`ifdef MEM_WB_FWD_EN
    check("fwd_valid", fwd_valid, 1);
    check("fwd_rd", fwd_rd, 5);
    check("fwd_data", fwd_data, 20'h00042);
`endif
    out_ready = 1'b1;
    drive(1'b1, 4'h1, 16'h0077, 20'h0, 3'd7, 1'b0);
    tick();
    check("norw_out_regwrite", out_regwrite, 0);
    check("norw_wb_data", wb_data, 20'h00077);
`ifdef MEM_WB_FWD_EN
    check("fwd_valid_norw", fwd_valid, 0);
`endif
    drive(1'b0, 4'h0, 16'h0, 20'h0, 3'd0, 1'b0);
    tick();
`ifdef MEM_WB_FWD_EN
    check("fwd_valid_empty", fwd_valid, 0);
`endif
    check("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
